// File: rtl/byte_tx_arbiter.sv
// byte_tx_arbiter: edge-detects two byte sources, buffers each in a small FIFO
// and round-robins the bytes onto one start/busy byte transmitter.
module byte_tx_arbiter #(
   parameter int DEPTH        = 4,
   parameter int PTR_W        = 2,
   parameter int BUSY_TIMEOUT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  a_data,
   input  logic        a_send,
   input  logic [7:0]  b_data,
   input  logic        b_send,
   input  logic        tx_busy,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   output logic        a_full,
   output logic        b_full,
   output logic        a_drop,
   output logic        b_drop,
   output logic        last_src,
   output logic [15:0] sent_count
);
   localparam int TW = $clog2(BUSY_TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
   state_t            state_q, state_d;
   logic [TW-1:0]     tmr_q, tmr_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              tx_start_q, tx_start_d;
   logic              last_q, last_d;
   logic [15:0]       sent_q, sent_d;
   logic [1:0]        sd_q, sd_d;
   logic [1:0]        drop_q, drop_d;
   logic [7:0]        mem_q [2][DEPTH];
   logic [7:0]        mem_d [2][DEPTH];
   logic [PTR_W-1:0]  wp_q [2], wp_d [2], rp_q [2], rp_d [2];
   logic [PTR_W:0]    cnt_q [2], cnt_d [2];
   logic [1:0]        send, ne, cap, wr, pop;
   logic              gnt;
   logic [7:0]        din [2];
   assign send   = {b_send, a_send};
   assign din[0] = a_data;
   assign din[1] = b_data;
   assign ne     = {cnt_q[1] != '0, cnt_q[0] != '0};
   always_comb begin
      state_d    = state_q;
      tmr_d      = tmr_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      last_d     = last_q;
      sent_d     = sent_q;
      pop        = '0;
      gnt        = 1'b0;
      case (state_q)
         IDLE:
            if (!tx_busy && |ne) begin
               gnt        = (ne == 2'b11) ? ~last_q : ne[1];
               pop[gnt]   = 1'b1;
               tx_data_d  = mem_q[gnt][rp_q[gnt]];
               last_d     = gnt;
               tx_start_d = 1'b1;
               state_d    = START;
            end
         START: begin
            tmr_d   = '0;
            state_d = WAIT_BUSY;
         end
         // abandon the transfer if the transmitter never acknowledges it
         WAIT_BUSY:
            if (tx_busy) state_d = WAIT_DONE;
            else if (tmr_q == TW'(BUSY_TIMEOUT - 1)) state_d = IDLE;
            else tmr_d = tmr_q + 1'b1;
         WAIT_DONE:
            if (!tx_busy) begin
               sent_d  = sent_q + 16'd1;
               state_d = IDLE;
            end
         default: state_d = IDLE;
      endcase
   end
   // full is judged on the pre-pop count, so a same-edge pop cannot rescue a capture
   always_comb begin
      mem_d  = mem_q;
      wp_d   = wp_q;
      rp_d   = rp_q;
      cnt_d  = cnt_q;
      cap    = '0;
      wr     = '0;
      drop_d = '0;
      sd_d   = send;
      for (int s = 0; s < 2; s++) begin
         cap[s]    = send[s] & ~sd_q[s];
         wr[s]     = cap[s] & (cnt_q[s] != (PTR_W+1)'(DEPTH));
         drop_d[s] = cap[s] & ~wr[s];
         if (wr[s]) mem_d[s][wp_q[s]] = din[s];
         wp_d[s]  = wp_q[s] + PTR_W'(wr[s]);
         rp_d[s]  = rp_q[s] + PTR_W'(pop[s]);
         cnt_d[s] = cnt_q[s] + (PTR_W+1)'(wr[s]) - (PTR_W+1)'(pop[s]);
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         tmr_q      <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         last_q     <= 1'b1;
         sent_q     <= '0;
         sd_q       <= '0;
         drop_q     <= '0;
         wp_q       <= '{default: '0};
         rp_q       <= '{default: '0};
         cnt_q      <= '{default: '0};
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         last_q     <= last_d;
         sent_q     <= sent_d;
         sd_q       <= sd_d;
         drop_q     <= drop_d;
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         cnt_q      <= cnt_d;
         mem_q      <= mem_d;
      end
   end
   assign tx_data    = tx_data_q;
   assign tx_start   = tx_start_q;
   assign a_full     = cnt_q[0] == (PTR_W+1)'(DEPTH);
   assign b_full     = cnt_q[1] == (PTR_W+1)'(DEPTH);
   assign a_drop     = drop_q[0];
   assign b_drop     = drop_q[1];
   assign last_src   = last_q;
   assign sent_count = sent_q;
endmodule

// File: tb/tb_byte_tx_arbiter.sv
// tb_byte_tx_arbiter: directed stimulus with a scoreboard of expected {src,byte}
// grants, checked by an independent monitor on every tx_start pulse.
module tb_byte_tx_arbiter;
   logic        clk = 1'b0, rst = 1'b1;
   logic [7:0]  a_data = '0, b_data = '0;
   logic        a_send = 1'b0, b_send = 1'b0, tx_busy = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_start, a_full, b_full, a_drop, b_drop, last_src;
   logic [15:0] sent_count;
   int n_cmp = 0, n_bad = 0, n_start = 0, n_adrop = 0, n_bdrop = 0;
   int busy_mode = 0, busy_cnt = 0, s0 = 0;
   logic [8:0] sb_q [$];
   logic [8:0] e_item;

   byte_tx_arbiter dut (
      .clk(clk), .rst(rst), .a_data(a_data), .a_send(a_send), .b_data(b_data),
      .b_send(b_send), .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start),
      .a_full(a_full), .b_full(b_full), .a_drop(a_drop), .b_drop(b_drop),
      .last_src(last_src), .sent_count(sent_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // monitor: every tx_start pops the scoreboard; drop pulses are tallied per cycle
   initial forever begin
      @(negedge clk);
      if (tx_start) begin
         n_start++;
         if (sb_q.size() == 0) chk("tx_start with empty scoreboard", tx_start, 0);
         else begin
            e_item = sb_q.pop_front();
            chk("tx_data", tx_data, e_item[7:0]);
            chk("last_src", last_src, e_item[8]);
         end
      end
      n_adrop += a_drop;
      n_bdrop += b_drop;
   end

   // transmitter model: mode 0 answers tx_start with 10 busy cycles, 1 forces busy, 2 forces idle
   initial forever begin
      @(negedge clk);
      if (busy_mode == 0) begin
         if (tx_start) busy_cnt = 10;
         else if (busy_cnt > 0) busy_cnt--;
         tx_busy = busy_cnt > 0;
      end else tx_busy = (busy_mode == 1);
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_a(input logic [7:0] d);
      @(negedge clk); a_data = d; a_send = 1'b1;
      @(negedge clk); a_send = 1'b0;
   endtask

   task automatic pulse_ab(input logic [7:0] da, input logic [7:0] db);
      @(negedge clk); a_data = da; b_data = db; a_send = 1'b1; b_send = 1'b1;
      @(negedge clk); a_send = 1'b0; b_send = 1'b0;
   endtask

   task automatic chk_reset();
      chk("rst tx_data", tx_data, 0);
      chk("rst tx_start", tx_start, 0);
      chk("rst a_full", a_full, 0);
      chk("rst b_full", b_full, 0);
      chk("rst a_drop", a_drop, 0);
      chk("rst b_drop", b_drop, 0);
      chk("rst last_src", last_src, 1);
      chk("rst sent_count", sent_count, 0);
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1; a_send = 1'b0; b_send = 1'b0;
      @(negedge clk); chk_reset();
      rst = 1'b0;
   endtask

   initial begin
      // 1: single capture, tx_start the cycle after capture
      do_reset();
      sb_q.push_back({1'b0, 8'h5A});
      pulse_a(8'h5A);
      chk("t1 no start at capture", tx_start, 0);
      @(negedge clk);
      chk("t1 start latency", tx_start, 1);
      cycles(20);
      chk("t1 sent_count", sent_count, 1);
      chk("t1 last_src", last_src, 0);

      // 2: long strobe gives one capture
      do_reset();
      s0 = n_adrop;
      sb_q.push_back({1'b0, 8'h11});
      @(negedge clk); a_data = 8'h11; a_send = 1'b1;
      cycles(5); a_send = 1'b0;
      cycles(25);
      chk("t2 sent_count", sent_count, 1);
      chk("t2 no drop", n_adrop - s0, 0);

      // 3: round robin with both sources queued behind busy
      busy_mode = 1;
      do_reset();
      sb_q.push_back({1'b0, 8'h01});
      sb_q.push_back({1'b1, 8'h81});
      sb_q.push_back({1'b0, 8'h02});
      sb_q.push_back({1'b1, 8'h82});
      pulse_ab(8'h01, 8'h81);
      pulse_ab(8'h02, 8'h82);
      cycles(2);
      chk("t3 nothing sent while busy", sent_count, 0);
      busy_mode = 0;
      cycles(80);
      chk("t3 sent_count", sent_count, 4);

      // 4: overflow while the transmitter stalls
      do_reset();
      for (int i = 0; i < 5; i++) sb_q.push_back({1'b0, 8'h10 + 8'(i)});
      pulse_a(8'h10);
      cycles(3);
      busy_mode = 1;
      for (int i = 1; i < 5; i++) pulse_a(8'h10 + 8'(i));
      chk("t4 a_full", a_full, 1);
      chk("t4 b_full", b_full, 0);
      s0 = n_adrop;
      pulse_a(8'h15);
      cycles(2);
      chk("t4 one a_drop cycle", n_adrop - s0, 1);
      chk("t4 still full", a_full, 1);
      busy_mode = 0;
      cycles(120);
      chk("t4 sent_count", sent_count, 5);
      chk("t4 a_full cleared", a_full, 0);

      // 5: busy timeout; a later A byte shows exactly when IDLE resumes
      busy_mode = 2;
      do_reset();
      sb_q.push_back({1'b1, 8'hC3});
      @(negedge clk); b_data = 8'hC3; b_send = 1'b1;
      @(negedge clk); b_send = 1'b0;
      @(negedge clk); chk("t5 start", tx_start, 1);
      @(negedge clk);
      @(negedge clk); a_data = 8'h3C; a_send = 1'b1;
      sb_q.push_back({1'b0, 8'h3C});
      @(negedge clk); a_send = 1'b0;
      chk("t5 idle too early (a)", tx_start, 0);
      @(negedge clk); chk("t5 idle too early (b)", tx_start, 0);
      @(negedge clk); chk("t5 resume after timeout", tx_start, 1);
      cycles(10);
      chk("t5 sent_count", sent_count, 0);

      // 6: reset during WAIT_DONE with bytes queued
      busy_mode = 0;
      do_reset();
      sb_q.push_back({1'b0, 8'h20});
      pulse_a(8'h20);
      cycles(4);
      busy_mode = 1;
      pulse_ab(8'h21, 8'h91);
      cycles(1);
      rst = 1'b1;
      @(negedge clk);
      chk_reset();
      rst = 1'b0;
      busy_mode = 0;
      s0 = n_start;
      cycles(40);
      chk("t6 no start after reset", n_start - s0, 0);
      chk("t6 sent_count", sent_count, 0);
      chk("b_drop never", n_bdrop, 0);
      chk("scoreboard drained", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
